// File: rtl/selector41_rr_arbiter_pkg.sv
// selector41_rr_arbiter_pkg: shared types, constants and the round-robin pick helper
package selector41_rr_arbiter_pkg;
  localparam int N_REQ = 4;
  localparam int DEF_WIDTH = 4;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} stateT;
  // Lowest offset from ptr wins, so scan offsets high-to-low and let later hits overwrite
  function automatic logic [1:0] rrPick(input logic [N_REQ-1:0] req, input logic [1:0] ptr);
    logic [1:0] pick;
    pick = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) if (req[ptr + 2'(i)]) pick = ptr + 2'(i);
    return pick;
  endfunction
endpackage

// File: rtl/selector41_rr_arbiter_if.sv
// selector41_rr_arbiter_if: requester ports plus the shared downstream bus
interface selector41_rr_arbiter_if
  import selector41_rr_arbiter_pkg::*;
#(parameter int WIDTH = DEF_WIDTH);
  logic [N_REQ-1:0] iReq;
  logic [WIDTH-1:0] iC0, iC1, iC2, iC3;
  logic iReady;
  logic oValid;
  logic [WIDTH-1:0] oZ;
  logic [N_REQ-1:0] oGnt;
  logic oS0, oS1, oBusy;
  modport master (output iReq, iC0, iC1, iC2, iC3, iReady, input oValid, oZ, oGnt, oS0, oS1, oBusy);
  modport slave (input iReq, iC0, iC1, iC2, iC3, iReady, output oValid, oZ, oGnt, oS0, oS1, oBusy);
endinterface

// File: rtl/selector41_rr_arbiter_selector41.sv
// selector41: 4:1 datapath mux steered by two select bits
module selector41 #(parameter int WIDTH = 4) (
  input  logic [WIDTH-1:0] iC0, iC1, iC2, iC3,
  input  logic iS0, iS1,
  output logic [WIDTH-1:0] oZ
);
  assign oZ = iS1 ? (iS0 ? iC3 : iC2) : (iS0 ? iC1 : iC0);
endmodule

// File: rtl/selector41_rr_arbiter.sv
// selector41_rr_arbiter: round-robin arbiter sharing one 4:1 selector, bursts up to MAX_BURST beats per grant
module selector41_rr_arbiter
  import selector41_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MAX_BURST = 4
) (
  input logic iClk,
  input logic iRst_n,
  selector41_rr_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_BURST + 1);
  stateT state;
  logic [1:0] ptr, sel;
  logic [N_REQ-1:0] gnt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] muxZ;
  logic valid, accept, rel;
  assign valid = (state == ST_BUSY) && bus.iReq[sel];
  assign accept = valid && bus.iReady;
  assign rel = !bus.iReq[sel] || (accept && cnt == CW'(MAX_BURST - 1));
  selector41 #(.WIDTH(WIDTH)) uMux (
    .iC0(bus.iC0), .iC1(bus.iC1), .iC2(bus.iC2), .iC3(bus.iC3),
    .iS0(sel[0]), .iS1(sel[1]), .oZ(muxZ)
  );
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= ST_IDLE;
      ptr <= '0;
      cnt <= '0;
      gnt <= '0;
      sel <= '0;
    end else if (state == ST_IDLE) begin
      if (|bus.iReq) begin
        gnt <= N_REQ'(1) << rrPick(bus.iReq, ptr);
        sel <= rrPick(bus.iReq, ptr);
        cnt <= '0;
        state <= ST_BUSY;
      end
    end else if (rel) begin
      // sel keeps the last grant while idle; only gnt clears
      gnt <= '0;
      ptr <= sel + 2'd1;
      state <= ST_IDLE;
    end else if (accept) begin
      cnt <= cnt + CW'(1);
    end
  end
  assign bus.oValid = valid;
  assign bus.oZ = valid ? muxZ : '0;
  assign bus.oGnt = gnt;
  assign bus.oS0 = sel[0];
  assign bus.oS1 = sel[1];
  assign bus.oBusy = state == ST_BUSY;
endmodule

// File: tb/tb_selector41_rr_arbiter.sv
// tb_selector41_rr_arbiter: table-driven vectors plus hand-written multi-cycle sequences
module tb_selector41_rr_arbiter;
  import selector41_rr_arbiter_pkg::*;
  typedef struct {
    logic [3:0] req;
    logic rdy;
    logic [11:0] exp;
  } vecT;
  logic iClk = 1'b0;
  logic iRst_n = 1'b0;
  int compared = 0;
  int mismatched = 0;
  vecT vecs[$];
  selector41_rr_arbiter_if #(.WIDTH(4)) bus ();
  selector41_rr_arbiter #(.WIDTH(4), .MAX_BURST(4)) dut (.iClk(iClk), .iRst_n(iRst_n), .bus(bus.slave));
  always #5 iClk = ~iClk;
  function automatic logic [11:0] mk(input logic [3:0] g, input logic [1:0] s, input logic v, input logic b, input logic [3:0] z);
    return {g, s, v, b, z};
  endfunction
  function automatic logic [11:0] obs();
    return {bus.oGnt, bus.oS1, bus.oS0, bus.oValid, bus.oBusy, bus.oZ};
  endfunction
  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask
  task automatic doReset();
    iRst_n = 1'b0;
    bus.iReq = '0;
    bus.iReady = 1'b1;
    repeat (2) tick();
    iRst_n = 1'b1;
  endtask
  initial begin
    int beats;
    bool_done: begin end
    bus.iC0 = 4'b0001;
    bus.iC1 = 4'b0010;
    bus.iC2 = 4'b0100;
    bus.iC3 = 4'b1000;
    vecs.push_back('{4'b0100, 1'b1, mk(4'b0000, 2'd0, 0, 0, 4'b0000)});
    repeat (4) vecs.push_back('{4'b0100, 1'b1, mk(4'b0100, 2'd2, 1, 1, 4'b0100)});
    vecs.push_back('{4'b0100, 1'b1, mk(4'b0000, 2'd2, 0, 0, 4'b0000)});
    vecs.push_back('{4'b0000, 1'b1, mk(4'b0100, 2'd2, 0, 1, 4'b0000)});
    vecs.push_back('{4'b1111, 1'b1, mk(4'b0000, 2'd2, 0, 0, 4'b0000)});
    repeat (4) vecs.push_back('{4'b1111, 1'b1, mk(4'b1000, 2'd3, 1, 1, 4'b1000)});
    vecs.push_back('{4'b1111, 1'b1, mk(4'b0000, 2'd3, 0, 0, 4'b0000)});
    repeat (4) vecs.push_back('{4'b1111, 1'b1, mk(4'b0001, 2'd0, 1, 1, 4'b0001)});
    vecs.push_back('{4'b1111, 1'b1, mk(4'b0000, 2'd0, 0, 0, 4'b0000)});
    repeat (4) vecs.push_back('{4'b1111, 1'b1, mk(4'b0010, 2'd1, 1, 1, 4'b0010)});
    vecs.push_back('{4'b1111, 1'b1, mk(4'b0000, 2'd1, 0, 0, 4'b0000)});
    doReset();
    chk("reset", 16'(obs()), 16'(mk(4'b0000, 2'd0, 0, 0, 4'b0000)));
    foreach (vecs[k]) begin
      bus.iReq = vecs[k].req;
      bus.iReady = vecs[k].rdy;
      @(negedge iClk);
      chk($sformatf("vec%0d", k), 16'(obs()), 16'(vecs[k].exp));
      tick();
    end
    // backpressure: ready low for 3 cycles after beat 2, still exactly 4 beats
    doReset();
    bus.iReq = 4'b0010;
    tick();
    beats = 0;
    for (int c = 0; c < 20; c++) begin
      bus.iReady = !(c >= 2 && c <= 4);
      @(negedge iClk);
      if (!bus.oBusy) break;
      if (c >= 2 && c <= 4) chk($sformatf("stall%0d", c), 16'(obs()), 16'(mk(4'b0010, 2'd1, 1, 1, 4'b0010)));
      if (bus.oValid && bus.iReady) beats++;
      tick();
    end
    chk("stall_beats", 16'(beats), 16'd4);
    chk("stall_released", 16'(bus.oBusy), 16'd0);
    // requester 1 drops after two beats while requester 2 waits
    doReset();
    bus.iReq = 4'b0010;
    repeat (3) tick();
    bus.iReq = 4'b0100;
    @(negedge iClk);
    chk("drop_cycle", 16'(obs()), 16'(mk(4'b0010, 2'd1, 0, 1, 4'b0000)));
    tick();
    chk("drop_idle", 16'(obs()), 16'(mk(4'b0000, 2'd1, 0, 0, 4'b0000)));
    tick();
    chk("drop_regrant", 16'(obs()), 16'(mk(4'b0100, 2'd2, 1, 1, 4'b0100)));
    // async reset mid-burst
    doReset();
    bus.iReq = 4'b0100;
    repeat (2) tick();
    chk("pre_rst", 16'(obs()), 16'(mk(4'b0100, 2'd2, 1, 1, 4'b0100)));
    #2 iRst_n = 1'b0;
    #1 chk("async_rst", 16'(obs()), 16'd0);
    bus.iReq = 4'b1010;
    tick();
    iRst_n = 1'b1;
    @(negedge iClk);
    chk("rst_idle", 16'(obs()), 16'(mk(4'b0000, 2'd0, 0, 0, 4'b0000)));
    tick();
    chk("rst_regrant", 16'(obs()), 16'(mk(4'b0010, 2'd1, 1, 1, 4'b0010)));
    // pointer wrap after a grant to requester 3
    doReset();
    bus.iReq = 4'b0100;
    tick();
    bus.iReq = 4'b0000;
    tick();
    bus.iReq = 4'b1000;
    tick();
    chk("wrap_g3", 16'(obs()), 16'(mk(4'b1000, 2'd3, 1, 1, 4'b1000)));
    bus.iReq = 4'b0000;
    tick();
    bus.iReq = 4'b1001;
    tick();
    chk("wrap_g0", 16'(obs()), 16'(mk(4'b0001, 2'd0, 1, 1, 4'b0001)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
